// File: rtl/alu_acc_sequencer.sv
// Sequential front-end for the 4-bit combinational ALU: takes instructions over valid/ready,
// drives the ALU from registered state, captures its result into the accumulator.
module alu_acc_sequencer (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_op,
   input  logic [3:0] in_data,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [2:0] alu_sel,
   input  logic [3:0] alu_out,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_data,
   output logic       zero,
   output logic       err,
   output logic [7:0] instr_cnt
);

   localparam logic [3:0] OP_LDI = 4'b1000;
   localparam logic [3:0] OP_OUT = 4'b1001;
   localparam logic [3:0] OP_NOP = 4'b1010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      EMIT = 2'd2
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] acc;
   logic [3:0] op_q;
   logic [3:0] opnd_q;
   logic       accept;
   logic       retire;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = EXEC;
         EXEC:    state_nxt = (op_q == OP_OUT) ? EMIT : IDLE;
         EMIT:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Retire pulses on every EXEC->IDLE and EMIT->IDLE edge
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      retire    = 1'b0;
      case (state)
         IDLE:    in_ready = 1'b1;
         EXEC:    retire = (op_q != OP_OUT);
         EMIT:    begin
            out_valid = 1'b1;
            retire    = out_ready;
         end
         default: ;
      endcase
   end

   assign accept  = in_ready && in_valid;
   assign alu_a   = acc;
   assign alu_b   = opnd_q;
   assign alu_sel = op_q[2:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc       <= 4'd0;
         op_q      <= 4'd0;
         opnd_q    <= 4'd0;
         out_data  <= 4'd0;
         zero      <= 1'b1;
         err       <= 1'b0;
         instr_cnt <= 8'd0;
      end else begin
         if (accept) begin
            op_q   <= in_op;
            opnd_q <= in_data;
         end
         if (state == EXEC) begin
            if (!op_q[3]) begin
               acc  <= alu_out;
               zero <= (alu_out == 4'd0);
            end else if (op_q == OP_LDI) begin
               acc  <= opnd_q;
               zero <= (opnd_q == 4'd0);
            end else if (op_q == OP_OUT) begin
               out_data <= acc;
            end else if (op_q != OP_NOP) begin
               err <= 1'b1;
            end
         end
         if (retire) instr_cnt <= instr_cnt + 8'd1;
      end
   end

endmodule
